// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg
//   Shared definitions for the load/store unit: FSM state encodings, the
//   lane index width, the word-alignment mask and a small alignment helper.
//   No ports; imported by load_store_unit and byte_lane_mux.
package load_store_unit_pkg;

  localparam int          LANE_W     = 2;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/load_store_unit_byte_lane_mux.sv
// byte_lane_mux
//   Combinational little-endian byte lane helper.
//   i_word   : source 32-bit word (lane 0 = bits [7:0])
//   i_lane   : selected byte lane
//   i_byte   : byte to insert into the selected lane
//   o_merged : i_word with the selected lane replaced by i_byte
//   o_byte   : the selected lane of i_word
module byte_lane_mux
  import load_store_unit_pkg::*;
(
  input  logic [31:0]       i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [7:0]        i_byte,
  output logic [31:0]       o_merged,
  output logic [7:0]        o_byte
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign o_merged[gi*8 +: 8] = (i_lane == LANE_W'(gi)) ? i_byte : i_word[gi*8 +: 8];
    end
  endgenerate

  assign o_byte = i_word[{i_lane, 3'b000} +: 8];

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Initiator side of the 32-bit data-memory interface. Accepts one
//   load/store at a time, faults misaligned or out-of-range accesses, and
//   performs byte stores as read-modify-write of the aligned word.
//   clk, reset                : clock, asynchronous active-high reset
//   req_valid/req_ready       : request handshake (accept when both high)
//   req_load/req_byte         : access kind (load/store, byte/word)
//   req_addr/req_wdata        : byte address and store data
//   resp_valid/fault/rdata    : one-cycle completion with result
//   mem_address/write_en/
//   write_data/read_data      : memory port (read data is combinational)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_fault,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_address,
  output logic        mem_write_en,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] WA_MAX = 32'(MEM_BYTES - 4);

  lsu_state_t        r_state;
  logic              r_load;
  logic              r_byte;
  logic [LANE_W-1:0] r_lane;
  logic [7:0]        r_wbyte;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_fault;
  logic [31:0]       r_resp_rdata;
  logic [31:0]       r_mem_address;
  logic              r_mem_write_en;
  logic [31:0]       r_mem_write_data;

  logic [31:0] w_wa;
  logic        w_fault;
  logic [31:0] w_merged;
  logic [7:0]  w_lane_byte;

  assign w_wa    = word_align(req_addr);
  // Word accesses must be aligned; any access whose aligned word runs past
  // the end of memory is rejected.
  assign w_fault = (!req_byte && (req_addr[1:0] != 2'b00)) || (w_wa > WA_MAX);

  // Works on the live memory read data during READ; the results are
  // registered, so memory outputs never depend combinationally on inputs.
  byte_lane_mux u_lane_mux (
    .i_word   (mem_read_data),
    .i_lane   (r_lane),
    .i_byte   (r_wbyte),
    .o_merged (w_merged),
    .o_byte   (w_lane_byte)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_load           <= 1'b0;
      r_byte           <= 1'b0;
      r_lane           <= '0;
      r_wbyte          <= '0;
      r_req_ready      <= 1'b1;
      r_resp_valid     <= 1'b0;
      r_resp_fault     <= 1'b0;
      r_resp_rdata     <= '0;
      r_mem_address    <= '0;
      r_mem_write_en   <= 1'b0;
      r_mem_write_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_load      <= req_load;
            r_byte      <= req_byte;
            r_lane      <= req_addr[1:0];
            r_wbyte     <= req_wdata[7:0];
            r_req_ready <= 1'b0;
            if (w_fault) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_fault <= 1'b1;
              r_resp_rdata <= '0;
            end else if (req_load || req_byte) begin
              r_state       <= ST_READ;
              r_mem_address <= w_wa;
            end else begin
              r_state          <= ST_WRITE;
              r_mem_address    <= w_wa;
              r_mem_write_en   <= 1'b1;
              r_mem_write_data <= req_wdata;
            end
          end
        end
        ST_READ: begin
          if (r_load) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_byte ? {24'b0, w_lane_byte} : mem_read_data;
          end else begin
            // Byte store: write back the fetched word with one lane replaced.
            r_state          <= ST_WRITE;
            r_mem_write_en   <= 1'b1;
            r_mem_write_data <= w_merged;
          end
        end
        ST_WRITE: begin
          r_state        <= ST_RESP;
          r_mem_write_en <= 1'b0;
          r_resp_valid   <= 1'b1;
          r_resp_rdata   <= '0;
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_resp_fault <= 1'b0;
          r_resp_rdata <= '0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state        <= ST_IDLE;
          r_mem_write_en <= 1'b0;
          r_req_ready    <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_fault     = r_resp_fault;
  assign resp_rdata     = r_resp_rdata;
  assign mem_address    = r_mem_address;
  assign mem_write_en   = r_mem_write_en;
  assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Directed bench for load_store_unit with a 1 KiB word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_load;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_fault;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address;
  logic        mem_write_en;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_load       (req_load),
    .req_byte       (req_byte),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_fault     (resp_fault),
    .resp_rdata     (resp_rdata),
    .mem_address    (mem_address),
    .mem_write_en   (mem_write_en),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address[9:2]] <= mem_write_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string name, input logic ld, input logic by,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int exp_lat, input logic exp_fault,
                         input logic [31:0] exp_rdata, input int exp_writes,
                         input logic [31:0] exp_wdata);
    int          lat;
    int          writes;
    logic [31:0] wdat;
    logic [31:0] rd;
    logic        flt;
    lat = 0; writes = 0; wdat = '0; rd = '0; flt = 1'b0;
    @(negedge clk);
    chk({name, "/ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_load  = ld;
    req_byte  = by;
    req_addr  = addr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_write_en) begin
        writes++;
        wdat = mem_write_data;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        flt = resp_fault;
        break;
      end
    end
    chk({name, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "/fault"},   {31'b0, flt}, {31'b0, exp_fault});
    chk({name, "/rdata"},   rd, exp_rdata);
    chk({name, "/writes"},  32'(writes), 32'(exp_writes));
    if (exp_writes > 0) chk({name, "/wdata"}, wdat, exp_wdata);
    $display("txn %-12s load=%0d byte=%0d addr=0x%08h wdata=0x%08h -> lat=%0d fault=%0d rdata=0x%08h writes=%0d",
             name, ld, by, addr, wd, lat, flt, rd, writes);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0;
    #2;
    chk("reset/ready",      {31'b0, req_ready},    32'd1);
    chk("reset/resp_valid", {31'b0, resp_valid},   32'd0);
    chk("reset/resp_fault", {31'b0, resp_fault},   32'd0);
    chk("reset/resp_rdata", resp_rdata,            32'd0);
    chk("reset/mem_addr",   mem_address,           32'd0);
    chk("reset/mem_we",     {31'b0, mem_write_en}, 32'd0);
    chk("reset/mem_wdata",  mem_write_data,        32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: word store then word load
    run_req("st_w_104",  1'b0, 1'b0, 32'h104, 32'h11223344, 2, 1'b0, 32'h0,        1, 32'h11223344);
    run_req("ld_w_104",  1'b1, 1'b0, 32'h104, 32'h0,        2, 1'b0, 32'h11223344, 0, 32'h0);
    // 2: byte store into lane 1 (read-modify-write) and reload
    run_req("st_b_105",  1'b0, 1'b1, 32'h105, 32'h000000AB, 3, 1'b0, 32'h0,        1, 32'h1122AB44);
    run_req("ld_w_104b", 1'b1, 1'b0, 32'h104, 32'h0,        2, 1'b0, 32'h1122AB44, 0, 32'h0);
    // 3: byte load of lane 2
    run_req("ld_b_106",  1'b1, 1'b1, 32'h106, 32'h0,        2, 1'b0, 32'h00000022, 0, 32'h0);
    // 4: misaligned word accesses fault without touching memory
    run_req("st_w_102",  1'b0, 1'b0, 32'h102, 32'hFFFFFFFF, 1, 1'b1, 32'h0,        0, 32'h0);
    run_req("ld_w_3fe",  1'b1, 1'b0, 32'h3FE, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0);
    // 5: top-of-memory boundary
    run_req("st_b_3ff",  1'b0, 1'b1, 32'h3FF, 32'h123456CD, 3, 1'b0, 32'h0,        1, 32'hCD000000);
    run_req("ld_b_3ff",  1'b1, 1'b1, 32'h3FF, 32'h0,        2, 1'b0, 32'h000000CD, 0, 32'h0);
    run_req("ld_w_3fc",  1'b1, 1'b0, 32'h3FC, 32'h0,        2, 1'b0, 32'hCD000000, 0, 32'h0);
    run_req("ld_b_400",  1'b1, 1'b1, 32'h400, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0);
    run_req("ld_w_400",  1'b1, 1'b0, 32'h400, 32'h0,        1, 1'b1, 32'h0,        0, 32'h0);

    // 6: reset asserted while in WRITE abandons the store
    @(negedge clk);
    req_valid = 1'b1; req_load = 1'b0; req_byte = 1'b0;
    req_addr = 32'h104; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_wr/we_before", {31'b0, mem_write_en}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_wr/we_now",    {31'b0, mem_write_en}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_wr/ready",     {31'b0, req_ready},    32'd1);
    chk("rst_wr/resp",      {31'b0, resp_valid},   32'd0);
    chk("rst_wr/mem_word",  mem[65],               32'h1122AB44);
    $display("txn %-12s reset during WRITE -> we=%0d ready=%0d mem[0x104]=0x%08h",
             "rst_in_wr", mem_write_en, req_ready, mem[65]);
    run_req("ld_w_post", 1'b1, 1'b0, 32'h104, 32'h0,        2, 1'b0, 32'h1122AB44, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
